// File: rtl/scan_chain_ctrl.sv
// Mux-scan chain controller: shifts a pattern in, optionally pulses one capture
// cycle, shifts the chain back out and returns it over a valid/ready response.
module scan_chain_ctrl #(
  parameter int CHAIN_LEN = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 CK,
  input  logic                 RB,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [CHAIN_LEN-1:0] cmd_data,
  input  logic                 cmd_cap,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [CHAIN_LEN-1:0] rsp_data,
  output logic                 SEL,
  output logic                 TD,
  input  logic                 SO,
  output logic                 busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CAPT,
    S_UNLOAD,
    S_RESP
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] pat_q, pat_d;
  logic                 cap_q, cap_d;
  logic                 sel_q, sel_d;
  logic                 td_q, td_d;
  logic [CHAIN_LEN-1:0] rsp_q, rsp_d;

  // sel_d/td_d are the values the chain sees during the *next* cycle, so every
  // transition sets them for the state being entered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    cap_d   = cap_q;
    sel_d   = 1'b0;
    td_d    = 1'b0;
    rsp_d   = rsp_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          pat_d   = cmd_data;
          cap_d   = cmd_cap;
          cnt_d   = '0;
          state_d = S_LOAD;
          sel_d   = 1'b1;
          td_d    = cmd_data[CHAIN_LEN-1];
        end
      end
      S_LOAD: begin
        pat_d = pat_q << 1;
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (cap_q) begin
            state_d = S_CAPT;
          end else begin
            state_d = S_UNLOAD;
            sel_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          sel_d = 1'b1;
          td_d  = pat_q[CHAIN_LEN-2];
        end
      end
      S_CAPT: begin
        state_d = S_UNLOAD;
        sel_d   = 1'b1;
      end
      S_UNLOAD: begin
        // SO is the last cell's pre-shift Q; first bit out is the MSB
        for (int k = 0; k < CHAIN_LEN; k++) begin
          if (cnt_q == CNT_W'(CHAIN_LEN - 1 - k)) rsp_d[k] = SO;
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
          sel_d = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CK or negedge RB) begin
    if (!RB) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pat_q   <= '0;
      cap_q   <= 1'b0;
      sel_q   <= 1'b0;
      td_q    <= 1'b0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      cap_q   <= cap_d;
      sel_q   <= sel_d;
      td_q    <= td_d;
      rsp_q   <= rsp_d;
    end
  end

  assign SEL       = sel_q;
  assign TD        = td_q;
  assign rsp_data  = rsp_q;
  assign cmd_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign busy      = (state_q != S_IDLE);

endmodule
